// File: rtl/cga_pixel_shifter.sv
// cga_pixel_shifter
//
// Pixel-formation stage of the CGA video path. Each character cell this block
// captures the two video-RAM bytes (stage 1). In text mode it fetches the
// glyph row from a synchronous font ROM. In graphics mode it uses the bytes
// as they are. One cell later it serialises the cell from a 16-bit shifter
// (stage 2). The attribute byte and the CRTC controls are delayed by the same
// one cell, so they stay aligned with the pixels on screen.
//
// Ports
//   clk            dot clock, all state on rising edge
//   reset          asynchronous, active-high
//   pix_ce         one-clk pixel enable (pulses at least 3 clk apart)
//   load           cell boundary, qualified by pix_ce
//   vram_d0        character code (text) / graphics byte 0
//   vram_d1        attribute (text) / graphics byte 1
//   row_addr       glyph scanline, bits [2:0] used
//   grph_mode      graphics mode select
//   mode_640       640-wide 1 bpp select
//   de_in, hsync_in, vsync_in, cursor_in   cell-rate controls from the CRTC
//   font_addr      glyph ROM address {char, row}
//   font_data      glyph ROM data, valid one clk after font_addr
//   pix_in         text dot
//   c1, c0         320-mode colour bits
//   pix_640        640-mode dot
//   att_byte       attribute of the cell on screen (0 in graphics)
//   display_enable, hsync, vsync, cursor   controls of the cell on screen
//   underrun       sticky: a cell boundary arrived before the glyph fetch finished
module cga_pixel_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        load,
    input  logic [7:0]  vram_d0,
    input  logic [7:0]  vram_d1,
    input  logic [4:0]  row_addr,
    input  logic        grph_mode,
    input  logic        mode_640,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        cursor_in,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        pix_in,
    output logic        c0,
    output logic        c1,
    output logic        pix_640,
    output logic [7:0]  att_byte,
    output logic        display_enable,
    output logic        hsync,
    output logic        vsync,
    output logic        cursor,
    output logic        underrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        READY = 2'd3
    } fetch_state_t;

    fetch_state_t state, state_nxt;

    logic        capture;
    logic        shift_en;
    logic        font_we;
    logic        underrun_set;

    // Stage 1: captured cell
    logic [7:0]  char_p1;
    logic [7:0]  att_p1;
    logic [7:0]  font_p1;
    logic        grph_p1;
    logic        m640_p1;
    logic        de_p1;
    logic        hs_p1;
    logic        vs_p1;
    logic        cur_p1;

    // Stage 2: cell on screen
    logic [15:0] sh_p2;
    logic        grph_p2;
    logic        m640_p2;
    logic        de_p2;
    logic        hs_p2;
    logic        vs_p2;
    logic        cur_p2;

    // Only the low three scanline bits address a glyph row.
    logic        unused_row;
    assign unused_row = ^row_addr[4:3];

    assign capture  = pix_ce & load;
    assign shift_en = pix_ce & ~load;

    // ---------------- glyph fetch FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        font_we      = 1'b0;
        underrun_set = 1'b0;
        if (capture) begin
            // A new cell always restarts the fetch; an unfinished one is lost.
            underrun_set = (state == ADDR) || (state == DATA);
            state_nxt    = grph_mode ? READY : ADDR;
        end else begin
            unique case (state)
                ADDR:    state_nxt = DATA;
                DATA: begin
                    state_nxt = READY;
                    font_we   = 1'b1;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (underrun_set) begin
            underrun <= 1'b1;
        end
    end

    // ---------------- stage 1: capture ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_p1   <= 8'h00;
            att_p1    <= 8'h00;
            grph_p1   <= 1'b0;
            m640_p1   <= 1'b0;
            de_p1     <= 1'b0;
            hs_p1     <= 1'b0;
            vs_p1     <= 1'b0;
            cur_p1    <= 1'b0;
            font_addr <= 11'h000;
        end else if (capture) begin
            char_p1 <= vram_d0;
            att_p1  <= vram_d1;
            grph_p1 <= grph_mode;
            m640_p1 <= mode_640;
            de_p1   <= de_in;
            hs_p1   <= hsync_in;
            vs_p1   <= vsync_in;
            cur_p1  <= cursor_in;
            // Graphics cells issue no fetch, so the ROM address holds.
            if (!grph_mode) begin
                font_addr <= {vram_d0, row_addr[2:0]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            font_p1 <= 8'h00;
        end else if (font_we) begin
            font_p1 <= font_data;
        end
    end

    // ---------------- stage 2: transfer and shift ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_p2    <= 16'h0000;
            att_byte <= 8'h00;
            grph_p2  <= 1'b0;
            m640_p2  <= 1'b0;
            de_p2    <= 1'b0;
            hs_p2    <= 1'b0;
            vs_p2    <= 1'b0;
            cur_p2   <= 1'b0;
        end else if (capture) begin
            // Uses the stage-1 contents from before this edge.
            sh_p2    <= grph_p1 ? {char_p1, att_p1} : {font_p1, 8'h00};
            att_byte <= grph_p1 ? 8'h00 : att_p1;
            grph_p2  <= grph_p1;
            m640_p2  <= m640_p1;
            de_p2    <= de_p1;
            hs_p2    <= hs_p1;
            vs_p2    <= vs_p1;
            cur_p2   <= cur_p1;
        end else if (shift_en) begin
            // 320 mode consumes two bits per dot; a late load then shows zeros.
            if (grph_p2 && !m640_p2) begin
                sh_p2 <= {sh_p2[13:0], 2'b00};
            end else begin
                sh_p2 <= {sh_p2[14:0], 1'b0};
            end
        end
    end

    // ---------------- outputs ----------------
    assign pix_in         = ~grph_p2 & sh_p2[15];
    assign c1             = grph_p2 & ~m640_p2 & sh_p2[15];
    assign c0             = grph_p2 & ~m640_p2 & sh_p2[14];
    assign pix_640        = grph_p2 & m640_p2 & sh_p2[15];
    assign display_enable = de_p2;
    assign hsync          = hs_p2;
    assign vsync          = vs_p2;
    assign cursor         = cur_p2;

endmodule

// File: tb/tb_cga_pixel_shifter.sv
// Directed testbench for cga_pixel_shifter: text fetch, 320 and 640 graphics,
// control delay, early/late loads, underrun and reset during a glyph fetch.
module tb_cga_pixel_shifter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_ce = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  vram_d0 = 8'h00;
    logic [7:0]  vram_d1 = 8'h00;
    logic [4:0]  row_addr = 5'h1B;
    logic        grph_mode = 1'b0;
    logic        mode_640 = 1'b0;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        cursor_in = 1'b0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic        pix_in, c0, c1, pix_640;
    logic [7:0]  att_byte;
    logic        display_enable, hsync, vsync, cursor, underrun;

    int total = 0;
    int bad = 0;
    int gap = 4;

    logic [15:0] s_pix, s_cc, s_640, s_de, s_hs;
    logic [7:0]  s_att;

    cga_pixel_shifter dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .load(load),
        .vram_d0(vram_d0), .vram_d1(vram_d1), .row_addr(row_addr),
        .grph_mode(grph_mode), .mode_640(mode_640),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .cursor_in(cursor_in),
        .font_addr(font_addr), .font_data(font_data),
        .pix_in(pix_in), .c0(c0), .c1(c1), .pix_640(pix_640),
        .att_byte(att_byte), .display_enable(display_enable),
        .hsync(hsync), .vsync(vsync), .cursor(cursor), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Synchronous font ROM: glyph 0x66 at {0x41, row 3}, 0xFF everywhere else.
    always @(posedge clk) begin
        font_data <= (font_addr == 11'h20B) ? 8'h66 : 8'hFF;
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One pix_ce pulse; called and returns at a falling edge.
    task automatic tick(input logic ld);
        pix_ce = 1'b1;
        load   = ld;
        @(negedge clk);
        pix_ce = 1'b0;
        load   = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Captures a new cell and records n dots of the cell currently displayed.
    task automatic run_cell(input logic [7:0] d0, input logic [7:0] d1,
                            input logic g, input logic m,
                            input logic de, input logic hs, input int n);
        vram_d0 = d0; vram_d1 = d1; grph_mode = g; mode_640 = m;
        de_in = de; hsync_in = hs;
        s_pix = '0; s_cc = '0; s_640 = '0; s_de = '0; s_hs = '0;
        for (int i = 0; i < n; i++) begin
            tick(i == 0);
            if (i == 0) s_att = att_byte;
            s_pix[15-i] = pix_in;
            s_640[15-i] = pix_640;
            s_de[15-i]  = display_enable;
            s_hs[15-i]  = hsync;
            if (i < 8) s_cc[15-2*i -: 2] = {c1, c0};
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_pix", {12'h0, pix_in, c1, c0, pix_640}, 16'h0);
        check_val("rst_ctl", {12'h0, display_enable, hsync, vsync, cursor}, 16'h0);
        check_val("rst_faddr", {5'h0, font_addr}, 16'h0);
        check_val("rst_att", {8'h0, att_byte}, 16'h0);
        reset = 1'b0;
        @(negedge clk);

        // Text cell captured; the screen shows the post-reset zero cell.
        run_cell(8'h41, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        check_val("first_pix", s_pix, 16'h0);
        check_val("first_de", s_de, 16'h0);
        check_val("font_addr", {5'h0, font_addr}, 16'h020B);
        check_val("underrun0", {15'h0, underrun}, 16'h0);

        // 320 graphics captured; text glyph on screen.
        run_cell(8'hE4, 8'h1B, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        check_val("text_pix", s_pix, 16'h6600);
        check_val("text_att", {8'h0, s_att}, 16'h001E);
        check_val("text_cc", s_cc, 16'h0);
        check_val("text_640", s_640, 16'h0);
        check_val("grph_faddr", {5'h0, font_addr}, 16'h020B);

        // 640 graphics captured; 320 cell on screen.
        run_cell(8'hA5, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        check_val("g320_cc", s_cc, 16'hE41B);
        check_val("g320_pix", s_pix, 16'h0);
        check_val("g320_att", {8'h0, s_att}, 16'h0);
        check_val("g320_640", s_640, 16'h0);

        // Control cells captured; 640 cell on screen for 16 dots.
        run_cell(8'h42, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 16);
        check_val("g640_dots", s_640, 16'hA50F);
        check_val("g640_att", {8'h0, s_att}, 16'h0);
        check_val("g640_pix", s_pix, 16'h0);
        check_val("g640_cc", s_cc, 16'h0);

        run_cell(8'h42, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 8);
        check_val("x1_de", s_de, 16'h0);
        check_val("x1_pix", s_pix, 16'hFF00);
        check_val("x1_att", {8'h0, s_att}, 16'h0007);

        run_cell(8'h42, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 8);
        check_val("x2_de", s_de, 16'hFF00);
        check_val("x2_hs", s_hs, 16'h0);

        // Early load after 6 dots.
        run_cell(8'h42, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        check_val("x3_de", s_de, 16'h0);
        check_val("x3_hs", s_hs, 16'hFC00);
        check_val("early_pix", s_pix, 16'hFC00);

        // Late load after 10 dots: two trailing zeros; a fresh glyph starts.
        run_cell(8'h42, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        check_val("late_pix", s_pix, 16'hFF00);
        check_val("x4_hs", s_hs, 16'h0);

        run_cell(8'h42, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        check_val("pre_under", {15'h0, underrun}, 16'h0);

        // Back-to-back loads on consecutive clocks.
        gap = 1;
        vram_d0 = 8'h41; vram_d1 = 8'h3C;
        tick(1'b1);
        check_val("u1_under", {15'h0, underrun}, 16'h0);
        vram_d0 = 8'h42; vram_d1 = 8'h5A;
        tick(1'b1);
        check_val("u2_under", {15'h0, underrun}, 16'h1);
        check_val("stale_pix", {15'h0, pix_in}, 16'h1);
        check_val("stale_att", {8'h0, att_byte}, 16'h003C);
        gap = 4;
        for (int i = 0; i < 7; i++) tick(1'b0);
        check_val("under_sticky", {15'h0, underrun}, 16'h1);

        // Capture a text cell, then reset while the fetch is in ADDR.
        vram_d0 = 8'h42; vram_d1 = 8'h11;
        pix_ce = 1'b1; load = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0; load = 1'b0;
        check_val("pre_rst_pix", {15'h0, pix_in}, 16'h1);
        check_val("pre_rst_att", {8'h0, att_byte}, 16'h005A);
        check_val("pre_rst_faddr", {5'h0, font_addr}, 16'h0213);
        reset = 1'b1;
        #1;
        check_val("mid_rst_pix", {12'h0, pix_in, c1, c0, pix_640}, 16'h0);
        check_val("mid_rst_att", {8'h0, att_byte}, 16'h0);
        check_val("mid_rst_under", {15'h0, underrun}, 16'h0);
        check_val("mid_rst_faddr", {5'h0, font_addr}, 16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_cell(8'h41, 8'h1E, 1'b0, 1'b0, 1'b1, 1'b0, 8);
        check_val("resume_zero_pix", s_pix, 16'h0);
        check_val("resume_zero_de", s_de, 16'h0);
        run_cell(8'h42, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        check_val("resume_pix", s_pix, 16'h6600);
        check_val("resume_de", s_de, 16'hFF00);
        check_val("resume_att", {8'h0, s_att}, 16'h001E);
        check_val("resume_under", {15'h0, underrun}, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
